// File: rtl/cntr_arbiter.sv
// Round-robin scheduler that shares one up/down interval counter among NREQ requesters.
// The winner is latched in IDLE, the counter runs in RUN, and DONE pulses done for the owner.
module cntr_arbiter #(
  parameter int NREQ = 4,
  parameter int BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*BITS-1:0] i_req_len,
  input  logic [NREQ-1:0]      i_req_down,
  input  logic                 i_hold,
  output logic [NREQ-1:0]      o_grant,
  output logic [NREQ-1:0]      o_done,
  output logic                 o_busy,
  output logic [BITS-1:0]      o_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_g;
  logic [BITS-1:0] r_len;
  logic            r_dir;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [BITS-1:0] r_count;

  logic            w_any;
  logic            w_hit;
  logic [IW-1:0]   w_cand;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_g_next;
  logic            w_abort;
  logic            w_len_zero;
  logic [BITS-1:0] w_last;
  logic            w_terminal;

  // Index arithmetic modulo NREQ; NREQ need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [31:0] off);
    logic [31:0] sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NREQ)) begin
      sum = sum - 32'(NREQ);
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  // Winner search: first set request at or after r_ptr, wrapping around
  always_comb begin
    w_any  = 1'b0;
    w_hit  = 1'b0;
    w_cand = '0;
    w_win  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = wrap_add(r_ptr, 32'(k));
      w_hit  = i_req[w_cand] & ~w_any;
      w_win  = w_hit ? w_cand : w_win;
      w_any  = w_any | w_hit;
    end
  end

  // Owner-side decode; w_last is only consumed once len is known to be nonzero
  always_comb begin
    w_g_next   = wrap_add(r_g, 32'd1);
    w_abort    = ~i_req[r_g];
    w_len_zero = (r_len == '0);
    w_last     = r_len - BITS'(1);
    w_terminal = r_dir ? (r_count == '0) : (r_count == w_last);
  end

  // Scheduler state machine and shared counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_len   <= '0;
      r_dir   <= 1'b0;
      r_grant <= '0;
      r_done  <= '0;
      r_count <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g     <= w_win;
            r_len   <= i_req_len[w_win*BITS +: BITS];
            r_dir   <= i_req_down[w_win];
            r_grant <= NREQ'(1) << w_win;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_abort) begin
            r_grant <= '0;
            r_ptr   <= w_g_next;
            r_state <= S_IDLE;
          end else if (w_len_zero) begin
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_count <= r_dir ? w_last : '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort outranks both hold and the terminal-count check
          if (w_abort) begin
            r_grant <= '0;
            r_ptr   <= w_g_next;
            r_state <= S_IDLE;
          end else if (i_hold) begin
            r_state <= S_RUN;
          end else if (w_terminal) begin
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_count <= r_dir ? (r_count - BITS'(1)) : (r_count + BITS'(1));
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_ptr   <= w_g_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_count = r_count;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_cntr_arbiter.sv
// Self-checking bench for cntr_arbiter: directed scenarios followed by randomized intervals,
// each interval's timeline predicted from the scheduling rules by a transaction-level model.
module tb_cntr_arbiter;

  localparam int NREQ = 4;
  localparam int BITS = 32;

  logic                 clk;
  logic                 i_reset;
  logic [NREQ-1:0]      i_req;
  logic [NREQ*BITS-1:0] i_req_len;
  logic [NREQ-1:0]      i_req_down;
  logic                 i_hold;
  logic [NREQ-1:0]      o_grant;
  logic [NREQ-1:0]      o_done;
  logic                 o_busy;
  logic [BITS-1:0]      o_count;

  int n_chk;
  int n_fail;
  int m_ptr;
  logic [BITS-1:0] m_count;

  cntr_arbiter #(.NREQ(NREQ), .BITS(BITS)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_req_len  (i_req_len),
    .i_req_down (i_req_down),
    .i_hold     (i_hold),
    .o_grant    (o_grant),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_slot(input int s, input int len, input bit dn);
    i_req_len[s*BITS +: BITS] = BITS'(len);
    i_req_down[s] = dn;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    m_ptr = 0;
    m_count = '0;
    chk("rst_count", o_count, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
  endtask

  // act: 0 none, 1 drop req of the owner, 2 assert reset; act_at -1 means during LOAD
  task automatic interval(input int hold_at, input int hold_n, input int act, input int act_at,
                          input bit perturb);
    int w;
    int len;
    bit dn;
    int idx;
    int holds;
    logic [NREQ-1:0] oh;
    logic [BITS-1:0] exp_c;
    w = pick(i_req, m_ptr);
    if (w < 0) begin
      step();
      chk("idle_grant", o_grant, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_count", o_count, m_count);
      return;
    end
    len = int'(i_req_len[w*BITS +: BITS]);
    dn  = i_req_down[w];
    oh  = NREQ'(1) << w;
    step();
    chk("load_grant", o_grant, oh);
    chk("load_busy", o_busy, 1);
    chk("load_done", o_done, 0);
    chk("load_count", o_count, m_count);
    if (perturb) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j != w) i_req[j] = 1'($urandom);
        set_slot(j, $urandom_range(0, 6), 1'($urandom));
      end
    end
    if (act == 1 && act_at < 0) begin
      i_req[w] = 1'b0;
      step();
      chk("abl_grant", o_grant, 0);
      chk("abl_busy", o_busy, 0);
      chk("abl_done", o_done, 0);
      chk("abl_count", o_count, m_count);
      m_ptr = (w + 1) % NREQ;
      return;
    end
    step();
    if (len == 0) begin
      chk("z_done", o_done, oh);
      chk("z_grant", o_grant, oh);
      chk("z_count", o_count, m_count);
    end else begin
      idx = 0;
      holds = hold_n;
      exp_c = dn ? BITS'(len - 1) : '0;
      chk("run_start", o_count, exp_c);
      chk("run_done0", o_done, 0);
      forever begin
        if (act != 0 && idx == act_at) begin
          if (act == 1) begin
            i_req[w] = 1'b0;
            i_hold = (hold_n > 0);
            step();
            i_hold = 1'b0;
            chk("ab_grant", o_grant, 0);
            chk("ab_busy", o_busy, 0);
            chk("ab_done", o_done, 0);
            chk("ab_count", o_count, exp_c);
            m_count = exp_c;
            m_ptr = (w + 1) % NREQ;
          end else begin
            i_reset = 1'b1;
            step();
            i_reset = 1'b0;
            chk("mr_count", o_count, 0);
            chk("mr_grant", o_grant, 0);
            chk("mr_done", o_done, 0);
            chk("mr_busy", o_busy, 0);
            m_count = '0;
            m_ptr = 0;
          end
          return;
        end
        if (idx == hold_at && holds > 0) begin
          i_hold = 1'b1;
          holds--;
          step();
          i_hold = 1'b0;
          chk("hold_count", o_count, exp_c);
          chk("hold_done", o_done, 0);
          chk("hold_grant", o_grant, oh);
        end else if (idx == len - 1) begin
          step();
          chk("done_pulse", o_done, oh);
          chk("done_count", o_count, exp_c);
          chk("done_grant", o_grant, oh);
          break;
        end else begin
          step();
          idx++;
          exp_c = dn ? BITS'(len - 1 - idx) : BITS'(idx);
          chk("run_count", o_count, exp_c);
          chk("run_done", o_done, 0);
        end
      end
      m_count = exp_c;
    end
    step();
    chk("end_done", o_done, 0);
    chk("end_grant", o_grant, 0);
    chk("end_busy", o_busy, 0);
    chk("end_count", o_count, m_count);
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    i_reset = 1'b1;
    i_req = '0;
    i_req_len = '0;
    i_req_down = '0;
    i_hold = 1'b0;
    @(negedge clk);
    do_reset();

    // Single up request on requester 0
    set_slot(0, 3, 1'b0);
    i_req = 4'b0001;
    interval(-1, 0, 0, 0, 1'b0);
    i_req = 4'b0000;

    // Down request on requester 2
    set_slot(2, 4, 1'b1);
    i_req = 4'b0100;
    interval(-1, 0, 0, 0, 1'b0);
    i_req = 4'b0000;
    step();
    chk("down_stays0", o_count, 0);

    // Round robin from a clean pointer
    do_reset();
    for (int s = 0; s < NREQ; s++) set_slot(s, 1, 1'b0);
    i_req = 4'b1111;
    for (int n = 0; n < 5; n++) interval(-1, 0, 0, 0, 1'b0);
    chk("rr_ptr_model", 64'(m_ptr), 64'd1);
    i_req = 4'b0000;

    // Zero length, then hold for three RUN cycles
    set_slot(1, 0, 1'b0);
    i_req = 4'b0010;
    interval(-1, 0, 0, 0, 1'b0);
    set_slot(0, 5, 1'b0);
    i_req = 4'b0001;
    interval(2, 3, 0, 0, 1'b0);

    // Abort with another request pending
    set_slot(3, 2, 1'b0);
    i_req = 4'b1000;
    interval(-1, 0, 0, 0, 1'b0);
    set_slot(0, 10, 1'b0);
    set_slot(1, 2, 1'b0);
    i_req = 4'b0011;
    interval(-1, 0, 1, 4, 1'b0);
    interval(-1, 0, 0, 0, 1'b0);
    i_req = 4'b0000;

    // Reset mid-RUN, then check the pointer restarted at 0
    set_slot(2, 1, 1'b0);
    i_req = 4'b0100;
    interval(-1, 0, 0, 0, 1'b0);
    set_slot(0, 20, 1'b0);
    i_req = 4'b0001;
    interval(-1, 0, 2, 6, 1'b0);
    set_slot(0, 2, 1'b0);
    set_slot(3, 2, 1'b1);
    i_req = 4'b1001;
    interval(-1, 0, 0, 0, 1'b0);
    i_req = 4'b1000;
    interval(-1, 0, 0, 0, 1'b0);

    // Randomized intervals with holds, aborts and post-latch perturbation
    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < NREQ; s++) set_slot(s, $urandom_range(0, 6), 1'($urandom));
      i_req = NREQ'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        interval($urandom_range(0, 5), $urandom_range(0, 3), 1, $urandom_range(0, 6) - 1, 1'b1);
      end else begin
        interval($urandom_range(0, 5), $urandom_range(0, 3), 0, 0, 1'b1);
      end
      i_req = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
